// File: rtl/gpif_burst_buffer.sv
// rtl/gpif_burst_buffer.sv - ADC sample FIFO serving fixed-length FX3 GPIF bursts
module gpif_burst_buffer #(
    parameter int ADC_WIDTH    = 10,
    parameter int BUS_WIDTH    = 16,
    parameter int DEPTH_LOG2   = 14,
    parameter int BURST_WORDS  = 8192,
    parameter int READ_LATENCY = 2
) (
    input  logic                  inclk,
    input  logic                  reset,
    input  logic                  collectData,
    input  logic                  testMode,
    input  logic                  sampleValid,
    input  logic [ADC_WIDTH-1:0]  adcData,
    input  logic                  readData,
    output logic                  dataAvailable,
    output logic [BUS_WIDTH-1:0]  dataOut,
    output logic [DEPTH_LOG2:0]   fillLevel,
    output logic                  fullError,
    output logic                  emptyError
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int BCW   = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    localparam logic [DEPTH_LOG2:0] FULL_LVL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] BURST_LVL  = (DEPTH_LOG2 + 1)'(BURST_WORDS);
    localparam logic [BCW-1:0]      BURST_LAST = BCW'(BURST_WORDS - 1);
    localparam logic [3:0]          LAT_INIT   = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ} state_t;

    state_t                  state_q, state_d;
    logic                    collect_q, read_q;
    logic [3:0]              lat_q, lat_d;
    logic [BCW-1:0]          burst_q, burst_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     fill_q, fill_d;
    logic [ADC_WIDTH-1:0]    ramp_q, ramp_d;
    logic [BUS_WIDTH-1:0]    dout_q, dout_d;
    logic                    dav_q, dav_d;
    logic                    ferr_q, ferr_d;
    logic                    eerr_q, eerr_d;
    logic [BUS_WIDTH-1:0]    mem_q [DEPTH];

    logic                    flush;
    logic                    push_req, push_ok, pop_ok;
    logic [BUS_WIDTH-1:0]    word;

    // Datapath: flush detect, push/pop qualification, pointers, level, ramp and error flags
    always_comb begin
        flush    = collectData & ~collect_q;
        pop_ok   = (state_q == S_READ) && (fill_q != '0);
        push_req = collectData && sampleValid && !flush;
        // a pop frees a slot on the same edge, so a full FIFO still accepts a concurrent push
        push_ok  = push_req && ((fill_q != FULL_LVL) || pop_ok);
        word     = testMode ? BUS_WIDTH'(ramp_q) : BUS_WIDTH'(adcData);

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ramp_d   = (push_ok && testMode) ? ramp_q + 1'b1 : ramp_q;
        dout_d   = pop_ok ? mem_q[rd_ptr_q] : dout_q;

        fill_d = fill_q;
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        ferr_d = ferr_q | (push_req & ~push_ok);
    end

    // Burst FSM: IDLE advertises a full burst, WAIT covers read latency, READ pops BURST_WORDS
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        burst_d = burst_q;
        dav_d   = 1'b0;
        eerr_d  = eerr_q;
        case (state_q)
            S_IDLE: begin
                dav_d = (fill_q >= BURST_LVL);
                if (readData && dav_q) begin
                    dav_d   = 1'b0;
                    burst_d = '0;
                    lat_d   = LAT_INIT;
                    state_d = (READ_LATENCY == 1) ? S_READ : S_WAIT;
                end else if (readData && !read_q && !dav_q) begin
                    eerr_d = 1'b1;
                end
            end
            S_WAIT: begin
                // lat_q counts down so the first pop lands READ_LATENCY edges after capture
                if (lat_q <= 4'd1) begin
                    state_d = S_READ;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_READ: begin
                if (!pop_ok) begin
                    eerr_d = 1'b1;
                end
                if (burst_q == BURST_LAST) begin
                    burst_d = '0;
                    state_d = S_IDLE;
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Input history for collectData edge detection and readData rise detection
    always_ff @(posedge inclk) begin
        if (reset) begin
            collect_q <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            collect_q <= collectData;
            read_q    <= readData;
        end
    end

    // Control and status registers; a collectData rise clears everything like reset
    always_ff @(posedge inclk) begin
        if (reset || flush) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            burst_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ramp_q   <= '0;
            dout_q   <= '0;
            dav_q    <= 1'b0;
            ferr_q   <= 1'b0;
            eerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            burst_q  <= burst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ramp_q   <= ramp_d;
            dout_q   <= dout_d;
            dav_q    <= dav_d;
            ferr_q   <= ferr_d;
            eerr_q   <= eerr_d;
        end
    end

    // Sample storage; contents need no reset since the pointers define validity
    always_ff @(posedge inclk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign dataAvailable = dav_q;
    assign dataOut       = dout_q;
    assign fillLevel     = fill_q;
    assign fullError     = ferr_q;
    assign emptyError    = eerr_q;

endmodule

// File: tb/tb_gpif_burst_buffer.sv
// tb/tb_gpif_burst_buffer.sv - scoreboard and vector bench for gpif_burst_buffer
module tb_gpif_burst_buffer;

    localparam int AW = 10;
    localparam int BW = 16;
    localparam int DL = 4;
    localparam int NB = 4;
    localparam int RL = 2;
    localparam int DEPTH = 16;

    logic          inclk = 1'b0;
    logic          reset = 1'b1;
    logic          collectData = 1'b0;
    logic          testMode = 1'b0;
    logic          sampleValid = 1'b0;
    logic [AW-1:0] adcData = '0;
    logic          readData = 1'b0;
    logic          dataAvailable;
    logic [BW-1:0] dataOut;
    logic [DL:0]   fillLevel;
    logic          fullError;
    logic          emptyError;

    gpif_burst_buffer #(
        .ADC_WIDTH(AW), .BUS_WIDTH(BW), .DEPTH_LOG2(DL),
        .BURST_WORDS(NB), .READ_LATENCY(RL)
    ) dut (
        .inclk(inclk), .reset(reset), .collectData(collectData), .testMode(testMode),
        .sampleValid(sampleValid), .adcData(adcData), .readData(readData),
        .dataAvailable(dataAvailable), .dataOut(dataOut), .fillLevel(fillLevel),
        .fullError(fullError), .emptyError(emptyError)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        logic [AW-1:0] adc;
        logic [BW-1:0] exp_word;
    } vec_t;

    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            e0 = 0;
    int            n_pops = 0;
    bit            burst_act = 0;
    int            m_fill = 0;
    logic [AW-1:0] m_ramp = '0;
    logic          m_coll_q = 1'b0;
    logic [BW-1:0] m_dout = '0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] pop_log[$];
    vec_t          vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge: the scoreboard predicts pushes/pops from the inputs driven before it
    task automatic tick();
        bit flush, pop, push_ok;
        logic [BW-1:0] w;
        flush = collectData && !m_coll_q;
        pop   = burst_act && (cyc + 1 >= e0 + RL) && (cyc + 1 <= e0 + RL + NB - 1);
        @(posedge inclk);
        #1;
        cyc++;
        if (reset || flush) begin
            m_coll_q  = reset ? 1'b0 : collectData;
            exp_q.delete();
            m_fill    = 0;
            m_ramp    = '0;
            m_dout    = '0;
            burst_act = 0;
        end else begin
            m_coll_q = collectData;
            push_ok  = collectData && sampleValid && (m_fill < DEPTH || (pop && m_fill > 0));
            if (pop) begin
                n_pops++;
                pop_log.push_back(dataOut);
                if (exp_q.size() > 0) begin
                    m_dout = exp_q.pop_front();
                    m_fill--;
                end
                if (cyc == e0 + RL + NB - 1) burst_act = 0;
            end
            if (push_ok) begin
                w = testMode ? {6'b0, m_ramp} : {6'b0, adcData};
                exp_q.push_back(w);
                m_fill++;
                if (testMode) m_ramp++;
            end
        end
        chk("dataOut", 32'(dataOut), 32'(m_dout));
        chk("fillLevel", 32'(fillLevel), m_fill);
    endtask

    task automatic do_flush();
        collectData = 1'b0;
        tick();
        collectData = 1'b1;
        tick();
    endtask

    task automatic push_words(input int n, input int seed);
        sampleValid = 1'b1;
        for (int i = 0; i < n; i++) begin
            adcData = AW'(seed + i * 37);
            tick();
        end
        sampleValid = 1'b0;
    endtask

    task automatic wait_dav();
        for (int k = 0; k < 8 && !dataAvailable; k++) tick();
        chk("dav_before_req", 32'(dataAvailable), 1);
    endtask

    task automatic do_burst(input bit push_rd);
        wait_dav();
        readData  = 1'b1;
        burst_act = 1;
        e0        = cyc + 1;
        tick();
        readData = 1'b0;
        chk("dav_drop_on_req", 32'(dataAvailable), 0);
        for (int k = 1; k < RL; k++) tick();
        sampleValid = push_rd;
        for (int k = 0; k < NB; k++) begin
            adcData = AW'($urandom);
            tick();
        end
        sampleValid = 1'b0;
    endtask

    initial begin
        int sent;
        vecs[0] = '{10'h3FF, 16'h03FF};
        vecs[1] = '{10'h001, 16'h0001};
        vecs[2] = '{10'h200, 16'h0200};
        vecs[3] = '{10'h155, 16'h0155};

        // reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_fill", 32'(fillLevel), 0);
        chk("rst_dout", 32'(dataOut), 0);
        chk("rst_dav", 32'(dataAvailable), 0);
        chk("rst_ferr", 32'(fullError), 0);
        chk("rst_eerr", 32'(emptyError), 0);

        // 1: flush edge discards its sample, then a four-word table burst
        collectData = 1'b1;
        sampleValid = 1'b1;
        adcData     = 10'h2AA;
        tick();
        chk("t1_edge_discard", 32'(fillLevel), 0);
        for (int i = 0; i < 4; i++) begin
            adcData = vecs[i].adc;
            tick();
        end
        sampleValid = 1'b0;
        tick();
        chk("t1_dav_after_4", 32'(dataAvailable), 1);
        pop_log.delete();
        do_burst(0);
        chk("t1_pop_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            chk("t1_vec_word", 32'(pop_log[i]), 32'(vecs[i].exp_word));
        chk("t1_fill_end", 32'(fillLevel), 0);
        tick();
        chk("t1_dav_end", 32'(dataAvailable), 0);

        // 2: test ramp with continuous bursts, wrapping through 1023
        testMode = 1'b1;
        do_flush();
        n_pops = 0;
        sent   = 0;
        for (int g = 0; g < 2400; g++) begin
            sampleValid = (sent < 1030) && (g % 2 == 0);
            if (sampleValid) sent++;
            if (dataAvailable && !burst_act) begin
                readData  = 1'b1;
                burst_act = 1;
                e0        = cyc + 1;
            end else begin
                readData = 1'b0;
            end
            tick();
        end
        readData    = 1'b0;
        sampleValid = 1'b0;
        testMode    = 1'b0;
        chk("t2_pops", n_pops, 1028);
        chk("t2_last_word", 32'(dataOut), 3);
        chk("t2_fill_left", 32'(fillLevel), 2);
        chk("t2_ferr", 32'(fullError), 0);
        chk("t2_eerr", 32'(emptyError), 0);

        // 3: overrun drops the 17th sample; a flush clears the sticky flag
        do_flush();
        push_words(17, 5);
        chk("t3_fill_full", 32'(fillLevel), 16);
        chk("t3_ferr", 32'(fullError), 1);
        for (int b = 0; b < 4; b++) do_burst(0);
        chk("t3_fill_drained", 32'(fillLevel), 0);
        push_words(2, 100);
        do_flush();
        chk("t3_flush_fill", 32'(fillLevel), 0);
        chk("t3_flush_ferr", 32'(fullError), 0);

        // 4: request without a full burst buffered
        push_words(3, 200);
        tick();
        tick();
        chk("t4_dav_low", 32'(dataAvailable), 0);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        chk("t4_eerr", 32'(emptyError), 1);
        for (int k = 0; k < 4; k++) tick();
        chk("t4_fill_kept", 32'(fillLevel), 3);

        // 5: pushes on every pop edge keep the level constant
        push_words(1, 300);
        do_burst(1);
        chk("t5_fill", 32'(fillLevel), 4);
        chk("t5_dav_at_idle", 32'(dataAvailable), 0);
        tick();
        chk("t5_dav_next", 32'(dataAvailable), 1);

        // 6a: collectData re-rise at E0+3 aborts the burst
        readData  = 1'b1;
        burst_act = 1;
        e0        = cyc + 1;
        tick();
        readData = 1'b0;
        tick();
        collectData = 1'b0;
        tick();
        chk("t6_one_pop", 32'(fillLevel), 3);
        collectData = 1'b1;
        tick();
        chk("t6f_fill", 32'(fillLevel), 0);
        chk("t6f_dav", 32'(dataAvailable), 0);
        chk("t6f_eerr", 32'(emptyError), 0);
        for (int k = 0; k < 6; k++) tick();
        chk("t6f_no_pops", 32'(dataOut), 0);

        // 6b: reset at E0+3 gives the same outcome
        push_words(4, 400);
        wait_dav();
        readData  = 1'b1;
        burst_act = 1;
        e0        = cyc + 1;
        tick();
        readData = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6r_fill", 32'(fillLevel), 0);
        chk("t6r_dav", 32'(dataAvailable), 0);
        chk("t6r_dout", 32'(dataOut), 0);
        chk("t6r_eerr", 32'(emptyError), 0);
        for (int k = 0; k < 6; k++) tick();
        chk("t6r_idle_dav", 32'(dataAvailable), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
